// File: rtl/fp_converter_pipe.sv
// fp_converter_pipe: 3-stage pipelined two's-complement to small float converter.
//   S1: sign + magnitude, S2: leading-zero count + field extract + round bit,
//   S3: half-up rounding, exponent carry, saturation, pack.
// Output value = (-1)^S * F * 2^E. Valid/ready handshakes on both sides.
// Optional macro FP_CONVERTER_STATS_EN adds conv_count / sat_count outputs.
module fp_converter_pipe #(
  parameter int DATA_W = 12,
  parameter int EXP_W  = 3,
  parameter int MANT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] D,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              S,
  output logic [EXP_W-1:0]  E,
  output logic [MANT_W-1:0] F
`ifdef FP_CONVERTER_STATS_EN
  ,
  output logic [15:0]       conv_count,
  output logic [15:0]       sat_count
`endif
);

  localparam int K    = DATA_W - MANT_W;
  localparam int LZ_W = $clog2(DATA_W + 1);

  logic              v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic              adv1, adv2, adv3;
  logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [DATA_W-1:0] mag1_q, mag1_d;
  logic [EXP_W-1:0]  e2_q, e2_d, e3_q, e3_d;
  logic [MANT_W-1:0] f2_q, f2_d, f3_q, f3_d;
  logic              rb2_q, rb2_d;

  logic [DATA_W-1:0] neg, mag;
  logic [LZ_W-1:0]   lz;
  logic [DATA_W-1:0] shifted;
  logic [MANT_W:0]   f_sum;
  logic [EXP_W:0]    e_sum;
  logic              sat;
  logic [EXP_W-1:0]  e_res;
  logic [MANT_W-1:0] f_res;

  // Pipeline handshake: a stage moves only when the slot after it is free or draining now.
  always_comb begin
    adv3     = v2_q && (!v3_q || out_ready);
    adv2     = v1_q && (!v2_q || adv3);
    in_ready = !v1_q || adv2;
    adv1     = in_valid && in_ready;
    v1_d     = adv1 || (v1_q && !adv2);
    v2_d     = adv2 || (v2_q && !adv3);
    v3_d     = adv3 || (v3_q && !out_ready);
  end

  // S1: sign and magnitude; the most-negative input clamps to the largest positive magnitude.
  always_comb begin
    neg = -D;
    mag = D;
    if (D[DATA_W-1]) mag = neg[DATA_W-1] ? {1'b0, {(DATA_W-1){1'b1}}} : neg;
    s1_d   = adv1 ? D[DATA_W-1] : s1_q;
    mag1_d = adv1 ? mag : mag1_q;
  end

  // S2: leading-zero count over the full DATA_W magnitude, then field and round-bit extract.
  always_comb begin
    lz = LZ_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (mag1_q[i]) lz = LZ_W'(DATA_W - 1 - i);
    end
    shifted = '0;
    s2_d    = s2_q;
    e2_d    = e2_q;
    f2_d    = f2_q;
    rb2_d   = rb2_q;
    if (adv2) begin
      s2_d = s1_q;
      if (int'(lz) >= K) begin
        // Small magnitudes fit the significand directly; exponent stays 0 and nothing rounds.
        e2_d  = '0;
        f2_d  = mag1_q[MANT_W-1:0];
        rb2_d = 1'b0;
      end else begin
        // Exponent equals the right shift that puts the leading one at the significand MSB.
        e2_d    = EXP_W'(K - int'(lz));
        shifted = mag1_q >> (K - int'(lz) - 1);
        f2_d    = shifted[MANT_W:1];
        rb2_d   = shifted[0];
      end
    end
  end

  // S3: half-up rounding; a significand carry renormalises and may push E past its range.
  always_comb begin
    f_sum = {1'b0, f2_q} + {{MANT_W{1'b0}}, rb2_q};
    e_sum = {1'b0, e2_q} + {{EXP_W{1'b0}}, f_sum[MANT_W]};
    sat   = e_sum[EXP_W];
    if (sat) begin
      e_res = '1;
      f_res = '1;
    end else begin
      e_res = e_sum[EXP_W-1:0];
      f_res = f_sum[MANT_W] ? (MANT_W'(1) << (MANT_W - 1)) : f_sum[MANT_W-1:0];
    end
    s3_d = adv3 ? s2_q  : s3_q;
    e3_d = adv3 ? e_res : e3_q;
    f3_d = adv3 ? f_res : f3_q;
  end

  // Pipeline registers; reset drops every in-flight sample and zeroes the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      s1_q   <= 1'b0;
      mag1_q <= '0;
      s2_q   <= 1'b0;
      e2_q   <= '0;
      f2_q   <= '0;
      rb2_q  <= 1'b0;
      s3_q   <= 1'b0;
      e3_q   <= '0;
      f3_q   <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      s1_q   <= s1_d;
      mag1_q <= mag1_d;
      s2_q   <= s2_d;
      e2_q   <= e2_d;
      f2_q   <= f2_d;
      rb2_q  <= rb2_d;
      s3_q   <= s3_d;
      e3_q   <= e3_d;
      f3_q   <= f3_d;
    end
  end

  assign out_valid = v3_q;
  assign S         = s3_q;
  assign E         = e3_q;
  assign F         = f3_q;

`ifdef FP_CONVERTER_STATS_EN
  logic        sat3_q, sat3_d;
  logic [15:0] conv_q, conv_d, satc_q, satc_d;

  // Statistics: count output handshakes, and those carrying a saturated result.
  always_comb begin
    sat3_d = adv3 ? sat : sat3_q;
    conv_d = conv_q;
    satc_d = satc_q;
    if (v3_q && out_ready) begin
      conv_d = conv_q + 16'd1;
      if (sat3_q) satc_d = satc_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat3_q <= 1'b0;
      conv_q <= '0;
      satc_q <= '0;
    end else begin
      sat3_q <= sat3_d;
      conv_q <= conv_d;
      satc_q <= satc_d;
    end
  end

  assign conv_count = conv_q;
  assign sat_count  = satc_q;
`endif

endmodule

// File: tb/tb_fp_converter_pipe.sv
// Testbench for fp_converter_pipe (default parameters).
module tb_fp_converter_pipe;
  localparam int DW = 12;
  localparam int EW = 3;
  localparam int MW = 4;

  typedef struct packed {
    logic          s;
    logic [EW-1:0] e;
    logic [MW-1:0] f;
  } res_t;

  typedef struct {
    logic [DW-1:0] d;
    res_t          exp;
    bit            sat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] D = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          S;
  logic [EW-1:0] E;
  logic [MW-1:0] F;
`ifdef FP_CONVERTER_STATS_EN
  logic [15:0]   conv_count, sat_count;
`endif

  int n_checks = 0;
  int n_fail = 0;

  fp_converter_pipe #(.DATA_W(DW), .EXP_W(EW), .MANT_W(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .D(D),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .E(E), .F(F)
`ifdef FP_CONVERTER_STATS_EN
    , .conv_count(conv_count), .sat_count(sat_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: value-level conversion with integer arithmetic.
  function automatic res_t model(input logic [DW-1:0] d);
    res_t r;
    int mag, e, f, msb;
    mag = d[DW-1] ? (1 << DW) - int'(d) : int'(d);
    if (mag == (1 << (DW - 1))) mag = (1 << (DW - 1)) - 1;
    if (mag < (1 << MW)) begin
      e = 0;
      f = mag;
    end else begin
      msb = 0;
      while ((mag >> (msb + 1)) != 0) msb++;
      e = msb - (MW - 1);
      f = (mag + (1 << (e - 1))) >> e;
      if (f == (1 << MW)) begin
        f = 1 << (MW - 1);
        e = e + 1;
      end
      if (e > (1 << EW) - 1) begin
        e = (1 << EW) - 1;
        f = (1 << MW) - 1;
      end
    end
    r.s = d[DW-1];
    r.e = EW'(e);
    r.f = MW'(f);
    return r;
  endfunction

  vec_t       vecs[11];
  res_t       q[$];
  res_t       r;
  logic [DW-1:0] corner[4];
  bit         prev_stall;
  logic [31:0] prev_out;
  int         exp_sat;

  initial begin
    vecs[0]  = '{12'h001, '{1'b0, 3'd0, 4'h1}, 1'b0};
    vecs[1]  = '{12'hC2F, '{1'b1, 3'd6, 4'hF}, 1'b0};
    vecs[2]  = '{12'h03E, '{1'b0, 3'd3, 4'h8}, 1'b0};
    vecs[3]  = '{12'h800, '{1'b1, 3'd7, 4'hF}, 1'b1};
    vecs[4]  = '{12'h000, '{1'b0, 3'd0, 4'h0}, 1'b0};
    vecs[5]  = '{12'h00F, '{1'b0, 3'd0, 4'hF}, 1'b0};
    vecs[6]  = '{12'h010, '{1'b0, 3'd1, 4'h8}, 1'b0};
    vecs[7]  = '{12'hFFF, '{1'b1, 3'd0, 4'h1}, 1'b0};
    vecs[8]  = '{12'h7FF, '{1'b0, 3'd7, 4'hF}, 1'b1};
    vecs[9]  = '{12'h400, '{1'b0, 3'd7, 4'h8}, 1'b0};
    vecs[10] = '{12'h011, '{1'b0, 3'd1, 4'h9}, 1'b0};
    corner[0] = 12'h800; corner[1] = 12'h7FF; corner[2] = 12'h000; corner[3] = 12'hFFF;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sef", 32'({S, E, F}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef FP_CONVERTER_STATS_EN
    chk("rst_conv_count", 32'(conv_count), 32'd0);
`endif

    // Directed vectors with latency check, out_ready held high
    exp_sat = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; D = vecs[0].d;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk); in_valid = 1'b0; #1;
      chk("lat1_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk); #1;
      chk("lat2_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk); #1;
      chk("lat3_out_valid", 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_sef", i), 32'({S, E, F}), 32'(vecs[i].exp));
`ifdef FP_CONVERTER_STATS_EN
      chk($sformatf("vec%0d_sat_count", i), 32'(sat_count), 32'(exp_sat));
`endif
      if (vecs[i].sat) exp_sat++;
      if (i < 10) begin
        in_valid = 1'b1;
        D = vecs[i+1].d;
      end
    end
    @(negedge clk); #1;
    chk("directed_drained", 32'(out_valid), 32'd0);
`ifdef FP_CONVERTER_STATS_EN
    chk("conv_count_total", 32'(conv_count), 32'd11);
    chk("sat_count_total", 32'(sat_count), 32'd2);
`endif

    // Back-pressure: fill all three stages, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; D = vecs[i].d; #1;
      chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0; #1;
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    chk("bp_full_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk); #1;
    chk("bp_hold_sef", 32'({S, E, F}), 32'(vecs[0].exp));
    out_ready = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_out_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_order_%0d", i), 32'({S, E, F}), 32'(vecs[i].exp));
      @(negedge clk); #1;
    end
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset with samples in flight
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; D = vecs[1+i].d;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_pre_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0; #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sef", 32'({S, E, F}), 32'd0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk($sformatf("post_rst_no_stale_%0d", i), 32'(out_valid), 32'd0);
    end
`ifdef FP_CONVERTER_STATS_EN
    chk("post_rst_conv_count", 32'(conv_count), 32'd0);
`endif
    in_valid = 1'b1; D = 12'h001;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_sef", 32'({S, E, F}), 32'({1'b0, 3'd0, 4'h1}));
    @(negedge clk);

    // Randomised stream against the reference model with random back-pressure
    prev_stall = 1'b0;
    prev_out = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) D = corner[$urandom_range(0, 3)];
      else D = DW'($urandom);
      #1;
      if (prev_stall)
        chk("rand_hold", 32'({out_valid, S, E, F}), prev_out);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rand_unexpected_output", 32'd1, 32'd0);
        else begin
          r = q.pop_front();
          chk("rand_sef", 32'({S, E, F}), 32'(r));
        end
      end
      if (in_valid && in_ready) q.push_back(model(D));
      prev_stall = out_valid && !out_ready;
      prev_out = 32'({out_valid, S, E, F});
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) chk("drain_unexpected_output", 32'd1, 32'd0);
        else begin
          r = q.pop_front();
          chk("drain_sef", 32'({S, E, F}), 32'(r));
        end
      end
      @(negedge clk);
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_converter_pipe.md
FP_CONVERTER_PIPE -- requirements
Module: fp_converter_pipe

Interface
REQ-001 SHALL provide parameter DATA_W, default 12, two's-complement input width.
REQ-002 SHALL provide parameter EXP_W, default 3, exponent field width.
REQ-003 SHALL provide parameter MANT_W, default 4, significand field width; legal only if DATA_W-MANT_W-1 <= 2^EXP_W-1 and MANT_W >= 2.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, D holds a sample.
REQ-007 SHALL have port in_ready, output, 1, block accepts the sample this cycle.
REQ-008 SHALL have port D, input, DATA_W, two's-complement sample.
REQ-009 SHALL have port out_valid, output, 1, S/E/F hold a result.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-011 SHALL have ports S (1), E (EXP_W), F (MANT_W), outputs, sign/exponent/significand; value = (-1)^S * F * 2^E.

Function
REQ-012 SHALL transfer input when in_valid && in_ready and output when out_valid && out_ready, both on the same edge.
REQ-013 SHALL be a 3-stage pipeline: S1 sign + magnitude; S2 leading-zero count lz + field extract + round bit; S3 rounding + pack.
REQ-014 SHALL produce a result 3 cycles after acceptance when out_ready is held high; throughput 1 sample/cycle.
REQ-015 SHALL advance each stage only if its downstream slot is empty or being emptied the same cycle; in_ready = S1 empty or S1 advancing (no combinational path from in_valid to in_ready).
REQ-016 SHALL hold S/E/F/out_valid stable while out_valid && !out_ready; no sample lost or duplicated under any stall pattern.
REQ-017 SHALL compute magnitude as |D|; D = most-negative value (0x800 at default) SHALL map to magnitude 2^(DATA_W-1)-1.
REQ-018 SHALL set S to D[DATA_W-1], including for the most-negative case; D=0 gives S=0,E=0,F=0.
REQ-019 SHALL set, with K = DATA_W-MANT_W: if lz >= K then E=0, F=magnitude[MANT_W-1:0], no rounding; else E=K-lz, F=MANT_W bits starting at the leading one, round bit = next lower bit.
REQ-020 SHALL round half-up: if round bit=1, F=F+1; on carry-out F=2^(MANT_W-1) and E=E+1.
REQ-021 SHALL saturate when E would exceed 2^EXP_W-1 after rounding: E=all ones, F=all ones.

Reset
REQ-022 SHALL on rst_n low immediately clear all stage valid flags, drive out_valid=0, S=0, E=0, F=0; in_ready=1 from the first edge after release.
REQ-023 SHALL discard all in-flight samples on reset mid-operation; no partial result may emerge after release.

Configuration
REQ-024 SHALL, with macro FP_CONVERTER_STATS_EN defined, add outputs conv_count (16 bit, increments per output handshake) and sat_count (16 bit, increments per output handshake of a REQ-021 saturated result), both wrap at 0xFFFF->0, reset to 0.
REQ-025 SHALL, without FP_CONVERTER_STATS_EN, omit these ports and counters entirely; datapath behaviour identical.

Verification
REQ-026 SHALL test defaults, out_ready=1: D=12'h001 -> S=0,E=0,F=0001 after exactly 3 cycles.
REQ-027 SHALL test D=12'hC2F -> S=1,E=6,F=1111; D=12'h03E -> S=0,E=3,F=1000 (rounding carry).
REQ-028 SHALL test D=12'h800 -> S=1,E=7,F=1111, sat_count=1 when stats enabled.
REQ-029 SHALL test 3 back-to-back inputs with out_ready=0: in_ready falls only once all 3 stages are full; release out_ready -> 3 results in order, one per cycle.
REQ-030 SHALL test rst_n low with 2 samples in flight -> out_valid=0 asynchronously, no stale result after release; next input D=12'h001 yields S=0,E=0,F=0001.
